// File: rtl/pow8_sequencer_if.sv
// Operand/handshake bundle between the exponentiation front end and pow8_sequencer.
// The abort line exists only when POW8_ABORT_EN is defined.
interface pow8_sequencer_if #(
  parameter int EXP_W = 8
);
  logic             start_i;
  logic [7:0]       base_i;
  logic [EXP_W-1:0] exp_i;
`ifdef POW8_ABORT_EN
  logic             abort_i;
`endif
  logic             busy_o;
  logic             done_o;
  logic [7:0]       result_o;
  logic             ovf_o;

`ifdef POW8_ABORT_EN
  modport master (output start_i, base_i, exp_i, abort_i,
                  input  busy_o, done_o, result_o, ovf_o);
  modport slave  (input  start_i, base_i, exp_i, abort_i,
                  output busy_o, done_o, result_o, ovf_o);
`else
  modport master (output start_i, base_i, exp_i,
                  input  busy_o, done_o, result_o, ovf_o);
  modport slave  (input  start_i, base_i, exp_i,
                  output busy_o, done_o, result_o, ovf_o);
`endif
endinterface

// File: rtl/pow8_sequencer.sv
// Square-and-multiply base^exp mod 256 on one shared 8x8 Wallace multiplier, with exact overflow flag.
// Optional feature macro: POW8_ABORT_EN (adds abort of an in-flight operation).

module pow8_wallace8 (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] product_o
);
  logic [15:0] pp [8];
  logic [15:0] s1a, c1a, s1b, c1b;
  logic [15:0] s2a, c2a, s2b, c2b;
  logic [15:0] s3, c3, s4, c4;

  function automatic logic [15:0] csaSum(input logic [15:0] x, input logic [15:0] y,
                                         input logic [15:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [15:0] csaCarry(input logic [15:0] x, input logic [15:0] y,
                                           input logic [15:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = b_i[i] ? (16'(a_i) << i) : 16'h0000;
    end
  end

  // Carry-save reduction 8 -> 6 -> 4 -> 3 -> 2 rows, then one carry-propagate add.
  assign s1a = csaSum(pp[0], pp[1], pp[2]);
  assign c1a = csaCarry(pp[0], pp[1], pp[2]);
  assign s1b = csaSum(pp[3], pp[4], pp[5]);
  assign c1b = csaCarry(pp[3], pp[4], pp[5]);

  assign s2a = csaSum(s1a, c1a, s1b);
  assign c2a = csaCarry(s1a, c1a, s1b);
  assign s2b = csaSum(c1b, pp[6], pp[7]);
  assign c2b = csaCarry(c1b, pp[6], pp[7]);

  assign s3  = csaSum(s2a, c2a, s2b);
  assign c3  = csaCarry(s2a, c2a, s2b);

  assign s4  = csaSum(s3, c3, c2b);
  assign c4  = csaCarry(s3, c3, c2b);

  assign product_o = s4 + c4;
endmodule

module pow8_sequencer #(
  parameter int EXP_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  pow8_sequencer_if.slave bus
);
  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(EXP_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SQ,
    S_MUL,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       base_q, base_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ovfAcc_q, ovfAcc_d;
  logic [7:0]       result_q, result_d;
  logic             ovf_q, ovf_d;

  logic [7:0]       mulB;
  logic [15:0]      product;
  logic             prodHigh;

  // The multiplier squares acc in SQ and multiplies by the latched base in MUL.
  assign mulB = (state_q == S_MUL) ? base_q : acc_q;

  pow8_wallace8 uMul (
    .a_i      (acc_q),
    .b_i      (mulB),
    .product_o(product)
  );

  assign prodHigh = |product[15:8];

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    base_d   = base_q;
    exp_d    = exp_q;
    idx_d    = idx_q;
    ovfAcc_d = ovfAcc_q;
    result_d = result_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          base_d   = bus.base_i;
          exp_d    = bus.exp_i;
          acc_d    = 8'd1;
          ovfAcc_d = 1'b0;
          idx_d    = IDX_LAST;
          state_d  = S_SQ;
        end
      end
      S_SQ: begin
        acc_d    = product[7:0];
        ovfAcc_d = ovfAcc_q | prodHigh;
        if (exp_q[idx_q]) begin
          state_d = S_MUL;
        end else if (idx_q == '0) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_MUL: begin
        acc_d    = product[7:0];
        ovfAcc_d = ovfAcc_q | prodHigh;
        if (idx_q == '0) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q - 1'b1;
          state_d = S_SQ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef POW8_ABORT_EN
    if (bus.abort_i && ((state_q == S_SQ) || (state_q == S_MUL))) begin
      state_d = S_IDLE;
    end
`endif

    // Result registers load only on the way into DONE, so they hold until the next pulse.
    if (state_d == S_DONE) begin
      result_d = acc_d;
      ovf_d    = ovfAcc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= 8'd1;
      base_q   <= 8'd0;
      exp_q    <= '0;
      idx_q    <= '0;
      ovfAcc_q <= 1'b0;
      result_q <= 8'h00;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      idx_q    <= idx_d;
      ovfAcc_q <= ovfAcc_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy_o   = (state_q != S_IDLE);
  assign bus.done_o   = (state_q == S_DONE);
  assign bus.result_o = result_q;
  assign bus.ovf_o    = ovf_q;
endmodule
